// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encoding,
// requester port ids and default sizing.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   localparam int MEM_DEPTH       = 512;
   localparam int DEF_WAIT_CYCLES = 1;

   // wait counter wide enough for the legal 1..15 access length
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// slave  : arbiter view (drives acks, read data and memory pins)
// master : requesters + memory view
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_data_out;

   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
      output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
             mem_address, mem_data_in, mem_read, mem_write, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
      input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
             mem_address, mem_data_in, mem_read, mem_write, busy
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant selector.
// MEM_ARB_ROUND_ROBIN_EN: a tie goes to the port not granted last time;
// otherwise the data port always beats instruction fetch.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
   input  logic last_grant,
   output logic grant,
   output logic grant_vld
);

   // choose the winning port among the active requests
   always_comb begin
      grant_vld = if_req | d_req;
      grant     = PORT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (if_req && d_req)
         grant = ~last_grant;
      else if (d_req)
         grant = PORT_D;
`else
      if (d_req)
         grant = PORT_D;
`endif
   end

`ifndef MEM_ARB_ROUND_ROBIN_EN
   // fixed priority ignores the history input
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port main memory arbiter between instruction fetch (IF) and the
// load/store data port (D). One transaction at a time:
// IDLE -> ACCESS (WAIT_CYCLES strobe cycles) -> RESP (ack pulse) -> IDLE,
// with ACCESS skipped for out-of-range addresses.
// Optional: MEM_ARB_ROUND_ROBIN_EN switches tie-break to round robin.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = MEM_DEPTH,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
)(
   input logic              clock,
   input logic              clear,
   mem_port_arbiter_if.slave bus
);

   state_e            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              gnt_port;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic              fault;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              last_grant;

   logic              pick_port;
   logic              pick_vld;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic              sel_fault;

   mem_arb_pick u_pick (
      .if_req     (bus.if_req),
      .d_req      (bus.d_req),
      .last_grant (last_grant),
      .grant      (pick_port),
      .grant_vld  (pick_vld)
   );

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // remember who won the most recent grant for the next tie
   always_ff @(posedge clock) begin
      if (clear)
         last_grant <= PORT_IF;
      else if (state == IDLE && pick_vld)
         last_grant <= pick_port;
   end
`else
   assign last_grant = PORT_IF;
`endif

   // request fields of the winning port and its range check
   always_comb begin
      sel_addr  = (pick_port == PORT_D) ? bus.d_addr : bus.if_addr;
      sel_we    = (pick_port == PORT_D) && bus.d_we;
      sel_fault = (sel_addr >= ADDR_W'(DEPTH));
   end

   // state register
   always_ff @(posedge clock) begin
      if (clear)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = sel_fault ? RESP : ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // latch the granted request, count strobe cycles, capture read data
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt        <= '0;
         gnt_port   <= PORT_IF;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         fault      <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt_port  <= pick_port;
                  lat_addr  <= sel_addr;
                  lat_we    <= sel_we;
                  lat_wdata <= bus.d_wdata;
                  fault     <= sel_fault;
                  cnt       <= CNT_W'(WAIT_CYCLES - 1);
                  // a faulting access returns zero data to its own port
                  if (sel_fault) begin
                     if (pick_port == PORT_D)
                        d_rdata_q <= '0;
                     else
                        if_rdata_q <= '0;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (!lat_we) begin
                     if (gnt_port == PORT_D)
                        d_rdata_q <= bus.mem_data_out;
                     else
                        if_rdata_q <= bus.mem_data_out;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // outputs decoded from state; memory pins idle at zero outside ACCESS
   always_comb begin
      bus.if_ack      = (state == RESP) && (gnt_port == PORT_IF);
      bus.d_ack       = (state == RESP) && (gnt_port == PORT_D);
      bus.if_err      = bus.if_ack && fault;
      bus.d_err       = bus.d_ack && fault;
      bus.mem_read    = (state == ACCESS) && !lat_we;
      bus.mem_write   = (state == ACCESS) && lat_we;
      bus.mem_address = (state == ACCESS) ? lat_addr : '0;
      bus.mem_data_in = ((state == ACCESS) && lat_we) ? lat_wdata : '0;
      bus.busy        = (state != IDLE);
      bus.if_rdata    = if_rdata_q;
      bus.d_rdata     = d_rdata_q;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port 512-word main memory between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Sits between the control unit/datapath and the memory. It is the only driver of the memory's address, data_in, read and write pins.
- Each access is a registered transaction with a configurable number of access cycles, a one-cycle ack pulse, a registered read-data return and an out-of-range error flag.

Parameters:
- ADDR_W, 32, requester and memory address width.
- DATA_W, 32, data width.
- DEPTH, 512, number of implemented memory words; addresses >= DEPTH fault.
- WAIT_CYCLES, 1, cycles the memory strobe is held per access (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle completion pulse for a fetch.
- if_rdata  out  DATA_W  fetched word; valid from the if_ack cycle until the next IF grant.
- if_err  out  1  qualifies if_ack; address was out of range.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable with d_req.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse for a data access.
- d_rdata  out  DATA_W  load result; valid from d_ack until the next D grant.
- d_err  out  1  qualifies d_ack; address was out of range.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_data_out  in  DATA_W  from memory data_out (combinational in memory).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clock and reset are fixed as one clock `clock` with a synchronous, active-high reset `clear`.
  - With clear high on a rising edge: state=IDLE, wait counter=0, last_grant=IF.
  - All outputs are 0: acks, errs, rdata regs, mem_* and busy.
  - clear mid-transaction aborts it. No ack is issued, and mem_write drops on the next edge.
- States: IDLE -> ACCESS -> RESP -> IDLE. ACCESS is skipped on fault.
- IDLE:
  - Sample the requests. Fixed priority: D over IF.
  - On grant, latch the port id, address, we and wdata into internal registers. Requester inputs are not used again for this transaction.
  - If latched address < DEPTH, go to ACCESS with counter=WAIT_CYCLES-1. Otherwise go to RESP with fault=1.
- ACCESS:
  - mem_address and mem_data_in are driven from the latched registers.
  - mem_read = !we and mem_write = we, both held for exactly WAIT_CYCLES cycles.
  - mem_read and mem_write are never high together, and both are 0 outside ACCESS.
  - On the last ACCESS cycle, mem_data_out is captured into the granted port's rdata register (loads and fetches only). Then go to RESP.
- RESP:
  - Pulse the granted port's ack for 1 cycle. err = fault.
  - On a fault, rdata is forced to 0 and no memory strobe occurs.
  - The ungranted port's rdata is unchanged. Return to IDLE.
- Latency:
  - req high in IDLE at cycle N gives ack at cycle N+WAIT_CYCLES+1.
  - Fault gives ack at N+1.
  - Minimum back-to-back period is WAIT_CYCLES+2 cycles.
- A req still high in the cycle after its ack is a new request; requesters must drop req on the ack cycle.
- Simultaneous requests: D is served first. IF waits, with its own inputs held, and is served on the next IDLE visit.
- Address comparison is unsigned, at full ADDR_W.
- mem_address carries the latched address unchanged.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port that was not last granted wins. last_grant updates at each grant and resets to IF, so D wins the first tie.
- Undefined: fixed D-over-IF priority, and the last_grant register is not present.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - port id constants PORT_IF=1'b0, PORT_D=1'b1;
  - DEPTH and the default WAIT_CYCLES.
- One sub-module, mem_arb_pick: a combinational 2-way grant selector (inputs: reqs and last_grant; output: grant id plus valid). It is the only place the ifdef switches behaviour.

Test Plan:
- Preload mem[0]=0x0000_0095; IF req addr 0, WAIT_CYCLES=1 -> mem_read high for exactly 1 cycle, if_ack at N+2, if_rdata=0x95, if_err=0.
- D store addr 0x87, wdata 0x43, then D load addr 0x87 -> mem_write high exactly 1 cycle, mem_read never high during the store, load returns d_rdata=0x43.
- IF and D both req in the same cycle (fixed priority) -> d_ack first, if_ack exactly WAIT_CYCLES+2 cycles later, mem_read/mem_write never both high.
- D load addr 0x200 (512) -> no mem strobe, d_ack at N+1 with d_err=1, d_rdata=0.
- WAIT_CYCLES=3, store in progress, clear asserted in the 2nd ACCESS cycle -> next edge: all outputs 0, state IDLE, no d_ack ever.
- With MEM_ARB_ROUND_ROBIN_EN, three successive simultaneous IF+D ties -> grant order D, IF, D.
